// File: rtl/gray_updown_counter.sv
// gray_updown_counter: binary up/down counter that also presents its count in
// reflected-binary Gray code. The count lives in one binary register; the Gray
// value and the flags are registered from the same next-count value. Every
// output therefore changes on the same edge, and the Gray output can be
// sampled glitch-free by another clock domain.
module gray_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_wrap,
  output logic             o_at_max,
  output logic             o_at_min
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_at_max;
  logic             r_at_min;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_next_cnt;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;
  logic             w_is_max;
  logic             w_is_min;

  assign w_is_max = (r_cnt == {WIDTH{1'b1}});
  assign w_is_min = (r_cnt == {WIDTH{1'b0}});

  // Gray-to-binary for the load path: prefix XOR running from the MSB down.
  always_comb begin
    w_load_bin = '0;
    w_load_bin[WIDTH-1] = i_load_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_load_bin[i] = w_load_bin[i+1] ^ i_load_gray[i];
    end
  end

  // Next count: load beats count beats hold; a wrap pulse only comes from a
  // counting step that crosses an end while not saturating.
  always_comb begin
    w_next_cnt  = r_cnt;
    w_next_wrap = 1'b0;
    if (i_load) begin
      w_next_cnt = w_load_bin;
    end else if (i_en) begin
      if (i_up) begin
        if (!w_is_max) begin
          w_next_cnt = r_cnt + ONE;
        end else if (!i_sat) begin
          w_next_cnt  = '0;
          w_next_wrap = 1'b1;
        end
      end else begin
        if (!w_is_min) begin
          w_next_cnt = r_cnt - ONE;
        end else if (!i_sat) begin
          w_next_cnt  = {WIDTH{1'b1}};
          w_next_wrap = 1'b1;
        end
      end
    end
  end

  assign w_next_gray = w_next_cnt ^ (w_next_cnt >> 1);

  // State and all outputs are registered together from the next count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_gray   <= '0;
      r_wrap   <= 1'b0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
    end else begin
      r_cnt    <= w_next_cnt;
      r_gray   <= w_next_gray;
      r_wrap   <= w_next_wrap;
      r_at_max <= (w_next_cnt == {WIDTH{1'b1}});
      r_at_min <= (w_next_cnt == {WIDTH{1'b0}});
    end
  end

  assign o_bin    = r_cnt;
  assign o_gray   = r_gray;
  assign o_wrap   = r_wrap;
  assign o_at_max = r_at_max;
  assign o_at_min = r_at_min;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed bench for gray_updown_counter, covering a
// 4-bit instance for most scenarios and an 8-bit instance for the wide wrap.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en4 = 1'b0, up4 = 1'b0, sat4 = 1'b0, load4 = 1'b0;
  logic [3:0] loadGray4 = '0;
  logic [3:0] bin4, gray4;
  logic       wrap4, atMax4, atMin4;
  logic       en8 = 1'b0, up8 = 1'b0, sat8 = 1'b0, load8 = 1'b0;
  logic [7:0] loadGray8 = '0;
  logic [7:0] bin8, gray8;
  logic       wrap8, atMax8, atMin8;

  int testsRun = 0;
  int testsFailed = 0;

  logic [10:0] obs4;
  logic [18:0] obs8;
  assign obs4 = {bin4, gray4, wrap4, atMax4, atMin4};
  assign obs8 = {bin8, gray8, wrap8, atMax8, atMin8};

  gray_updown_counter #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en4), .i_up(up4), .i_sat(sat4),
    .i_load(load4), .i_load_gray(loadGray4), .o_bin(bin4), .o_gray(gray4),
    .o_wrap(wrap4), .o_at_max(atMax4), .o_at_min(atMin4)
  );

  gray_updown_counter #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en8), .i_up(up8), .i_sat(sat8),
    .i_load(load8), .i_load_gray(loadGray8), .o_bin(bin8), .o_gray(gray8),
    .o_wrap(wrap8), .o_at_max(atMax8), .o_at_min(atMin8)
  );

  always #5 clk = ~clk;

  // Expected {bin, gray, wrap, at_max, at_min} for the 4-bit instance.
  function automatic logic [10:0] exp4(input logic [3:0] b, input logic w);
    exp4 = {b, b ^ (b >> 1), w, (b == 4'hF), (b == 4'h0)};
  endfunction

  // One clock edge; outputs are then read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    step();
    step();
    testsRun++;
    if (obs4 !== 11'b0000_0000_0_0_1) begin
      testsFailed++;
      $display("[TB] FAIL reset4 got=%b exp=%b", obs4, 11'b0000_0000_0_0_1);
    end
    testsRun++;
    if (obs8 !== 19'b00000000_00000000_0_0_1) begin
      testsFailed++;
      $display("[TB] FAIL reset8 got=%b exp=%b", obs8, 19'b00000000_00000000_0_0_1);
    end
    rstN = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] prevGray;
    logic [3:0] expBin;
    prevGray = gray4;
    en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      expBin = 4'(k);
      testsRun++;
      if (obs4 !== exp4(expBin, (k == 16))) begin
        testsFailed++;
        $display("[TB] FAIL wrap_up k=%0d got=%b exp=%b", k, obs4, exp4(expBin, (k == 16)));
      end
      testsRun++;
      if ($countones(gray4 ^ prevGray) !== 1) begin
        testsFailed++;
        $display("[TB] FAIL wrap_up_onebit k=%0d got=%b prev=%b exp=one bit changed", k, gray4, prevGray);
      end
      if (k == 15) begin
        testsRun++;
        if (gray4 !== 4'b1000) begin
          testsFailed++;
          $display("[TB] FAIL wrap_up_gray15 got=%b exp=1000", gray4);
        end
      end
      prevGray = gray4;
    end
    en4 = 1'b0;
  endtask

  task automatic test_wrap_down();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    en4 = 1'b1; up4 = 1'b0; sat4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== 11'b1111_1000_1_1_0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_down_first got=%b exp=%b", obs4, 11'b1111_1000_1_1_0);
    end
    step();
    testsRun++;
    if (obs4 !== 11'b1110_1001_0_0_0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_down_second got=%b exp=%b", obs4, 11'b1110_1001_0_0_0);
    end
    en4 = 1'b0;
  endtask

  task automatic test_load();
    load4 = 1'b1; loadGray4 = 4'b1101; en4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== 11'b1001_1101_0_0_0) begin
      testsFailed++;
      $display("[TB] FAIL load_plain got=%b exp=%b", obs4, 11'b1001_1101_0_0_0);
    end
    load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
    step();
    testsRun++;
    if (bin4 !== 4'd10) begin
      testsFailed++;
      $display("[TB] FAIL load_then_count got=%0d exp=10", bin4);
    end
    load4 = 1'b1; loadGray4 = 4'b1101;
    step();
    testsRun++;
    if (obs4 !== 11'b1001_1101_0_0_0) begin
      testsFailed++;
      $display("[TB] FAIL load_beats_en got=%b exp=%b", obs4, 11'b1001_1101_0_0_0);
    end
    loadGray4 = 4'b1000;
    step();
    loadGray4 = 4'b0000; sat4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== 11'b0000_0000_0_0_1) begin
      testsFailed++;
      $display("[TB] FAIL load_no_wrap got=%b exp=%b", obs4, 11'b0000_0000_0_0_1);
    end
    load4 = 1'b0; en4 = 1'b0;
  endtask

  task automatic test_saturate();
    sat4 = 1'b1; load4 = 1'b1; loadGray4 = 4'b1000; en4 = 1'b0;
    step();
    load4 = 1'b0; en4 = 1'b1; up4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      testsRun++;
      if (obs4 !== 11'b1111_1000_0_1_0) begin
        testsFailed++;
        $display("[TB] FAIL sat_max k=%0d got=%b exp=%b", k, obs4, 11'b1111_1000_0_1_0);
      end
    end
    up4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== exp4(4'd14, 1'b0)) begin
      testsFailed++;
      $display("[TB] FAIL sat_leave_max got=%b exp=%b", obs4, exp4(4'd14, 1'b0));
    end
    load4 = 1'b1; loadGray4 = 4'b0000;
    step();
    load4 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      testsRun++;
      if (obs4 !== 11'b0000_0000_0_0_1) begin
        testsFailed++;
        $display("[TB] FAIL sat_min k=%0d got=%b exp=%b", k, obs4, 11'b0000_0000_0_0_1);
      end
    end
    en4 = 1'b0; sat4 = 1'b0;
  endtask

  task automatic test_mid_reset();
    rstN = 1'b0;
    step();
    rstN = 1'b1; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
    repeat (7) step();
    testsRun++;
    if (bin4 !== 4'd7) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_pre got=%0d exp=7", bin4);
    end
    rstN = 1'b0; load4 = 1'b1; loadGray4 = 4'b1111;
    step();
    testsRun++;
    if (obs4 !== 11'b0000_0000_0_0_1) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset got=%b exp=%b", obs4, 11'b0000_0000_0_0_1);
    end
    rstN = 1'b1; load4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== exp4(4'd1, 1'b0)) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_resume got=%b exp=%b", obs4, exp4(4'd1, 1'b0));
    end
    en4 = 1'b0;
  endtask

  task automatic test_hold();
    load4 = 1'b1; loadGray4 = 4'b1000;
    step();
    load4 = 1'b0; en4 = 1'b1; up4 = 1'b1; sat4 = 1'b0;
    step();
    testsRun++;
    if (obs4 !== 11'b0000_0000_1_0_1) begin
      testsFailed++;
      $display("[TB] FAIL hold_pre_wrap got=%b exp=%b", obs4, 11'b0000_0000_1_0_1);
    end
    en4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      up4 = ~up4;
      step();
      testsRun++;
      if (obs4 !== 11'b0000_0000_0_0_1) begin
        testsFailed++;
        $display("[TB] FAIL hold k=%0d got=%b exp=%b", k, obs4, 11'b0000_0000_0_0_1);
      end
    end
  endtask

  task automatic test_wrap_up8();
    logic [7:0] prevGray;
    logic [7:0] expBin;
    prevGray = gray8;
    en8 = 1'b1; up8 = 1'b1; sat8 = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      step();
      expBin = 8'(k);
      testsRun++;
      if (bin8 !== expBin || wrap8 !== (k == 256)) begin
        testsFailed++;
        $display("[TB] FAIL wrap_up8 k=%0d got bin=%0d wrap=%b exp bin=%0d wrap=%b",
                 k, bin8, wrap8, expBin, (k == 256));
      end
      testsRun++;
      if ($countones(gray8 ^ prevGray) !== 1) begin
        testsFailed++;
        $display("[TB] FAIL wrap_up8_onebit k=%0d got=%b prev=%b exp=one bit changed", k, gray8, prevGray);
      end
      if (k == 255) begin
        testsRun++;
        if (gray8 !== 8'b10000000 || atMax8 !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL wrap_up8_top got gray=%b max=%b exp gray=10000000 max=1", gray8, atMax8);
        end
      end
      prevGray = gray8;
    end
    en8 = 1'b0;
  endtask

  // Scenarios run in order; each leaves the 4-bit instance idle with en low.
  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load();
    test_saturate();
    test_mid_reset();
    test_hold();
    test_wrap_up8();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
